// File: rtl/egg_timer_ctrl.sv
// Egg-timer sequencer: BCD MM:SS setpoint, 1 s prescaler, IDLE/RUN/PAUSE/DONE control.
// Optional macro ALARM_TIMEOUT_EN: DONE returns to IDLE by itself after ALARM_SECS ticks.
module egg_timer_ctrl #(
  parameter int TICK_DIV   = 50000000,
  parameter int ALARM_SECS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       cook_time,
  input  logic       minutes,
  input  logic       seconds,
  output logic [2:0] m_tens,
  output logic [3:0] m_ones,
  output logic [2:0] s_tens,
  output logic [3:0] s_ones,
  output logic [1:0] state,
  output logic       alarm
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE = PW'(32'd1);

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, DONE = 2'b11} state_t;

  state_t        state_r, state_nxt_s;
  logic [13:0]   sp_r, sp_nxt_s, rm_r, rm_nxt_s, disp_nxt_s;
  logic [PW-1:0] presc_r, presc_nxt_s;
  logic          min_prev_r, sec_prev_r;
  logic          min_edge_s, sec_edge_s, tick_s, start_ok_s;

  // Packed time layout: {m_tens[13:11], m_ones[10:7], s_tens[6:4], s_ones[3:0]}.
  function automatic logic [6:0] bcd_inc59(input logic [6:0] f);
    logic [6:0] r;
    if (f[3:0] != 4'd9) r = {f[6:4], f[3:0] + 4'd1};
    else if (f[6:4] != 3'd5) r = {f[6:4] + 3'd1, 4'd0};
    else r = 7'd0;
    return r;
  endfunction

  function automatic logic [13:0] bcd_dec(input logic [13:0] t);
    logic [13:0] r;
    r = t;
    if (t[3:0] != 4'd0) r[3:0] = t[3:0] - 4'd1;
    else begin
      r[3:0] = 4'd9;
      if (t[6:4] != 3'd0) r[6:4] = t[6:4] - 3'd1;
      else begin
        r[6:4] = 3'd5;
        if (t[10:7] != 4'd0) r[10:7] = t[10:7] - 4'd1;
        else begin
          r[10:7]  = 4'd9;
          r[13:11] = t[13:11] - 3'd1;
        end
      end
    end
    return r;
  endfunction

`ifdef ALARM_TIMEOUT_EN
  localparam int CW = (ALARM_SECS > 1) ? $clog2(ALARM_SECS) : 1;
  localparam logic [CW-1:0] ACNT_LAST = CW'(ALARM_SECS - 1);
  localparam logic [CW-1:0] ACNT_ONE  = CW'(32'd1);
  logic [CW-1:0] acnt_r, acnt_nxt_s;
  logic          hold_r, hold_nxt_s;
  // After a timeout, IDLE must see cook_time low before it may start again.
  assign start_ok_s = ~hold_r;
`else
  logic unused_alarm_secs_s;
  assign unused_alarm_secs_s = (ALARM_SECS > 32'sd0);
  assign start_ok_s = 1'b1;
`endif

  assign min_edge_s = minutes & ~min_prev_r;
  assign sec_edge_s = seconds & ~sec_prev_r;
  assign tick_s     = (presc_r == TICK_LAST);

  // Next-state, setpoint, remaining-time and prescaler selection.
  always_comb begin
    state_nxt_s = state_r;
    sp_nxt_s    = sp_r;
    rm_nxt_s    = rm_r;
    presc_nxt_s = presc_r;
`ifdef ALARM_TIMEOUT_EN
    acnt_nxt_s  = {CW{1'b0}};
    hold_nxt_s  = hold_r & cook_time;
`endif
    case (state_r)
      IDLE: begin
        sp_nxt_s[13:7] = min_edge_s ? bcd_inc59(sp_r[13:7]) : sp_r[13:7];
        sp_nxt_s[6:0]  = sec_edge_s ? bcd_inc59(sp_r[6:0]) : sp_r[6:0];
        if (cook_time && (sp_r != 14'd0) && start_ok_s) begin
          state_nxt_s = RUN;
          rm_nxt_s    = sp_r;
          presc_nxt_s = {PW{1'b0}};
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (tick_s) begin
          rm_nxt_s    = bcd_dec(rm_r);
          presc_nxt_s = {PW{1'b0}};
        end else begin
          presc_nxt_s = presc_r + PRESC_ONE;
        end
        if (tick_s && (rm_r == 14'd1)) state_nxt_s = DONE;
        else if (!cook_time) state_nxt_s = PAUSE;
        else state_nxt_s = RUN;
      end
      PAUSE: begin
        if (minutes && seconds) state_nxt_s = IDLE;
        else if (cook_time) state_nxt_s = RUN;
        else state_nxt_s = PAUSE;
      end
      DONE: begin
`ifdef ALARM_TIMEOUT_EN
        presc_nxt_s = tick_s ? {PW{1'b0}} : presc_r + PRESC_ONE;
        acnt_nxt_s  = tick_s ? acnt_r + ACNT_ONE : acnt_r;
        if (!cook_time) state_nxt_s = IDLE;
        else if (tick_s && (acnt_r == ACNT_LAST)) begin
          state_nxt_s = IDLE;
          hold_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = DONE;
        end
`else
        if (!cook_time) state_nxt_s = IDLE;
        else state_nxt_s = DONE;
`endif
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Display follows the state being entered so digits and state change on the same edge.
  always_comb begin
    case (state_nxt_s)
      IDLE:       disp_nxt_s = sp_nxt_s;
      RUN, PAUSE: disp_nxt_s = rm_nxt_s;
      DONE:       disp_nxt_s = 14'd0;
      default:    disp_nxt_s = 14'd0;
    endcase
  end

  // Core state, edge history and registered outputs; enable low freezes everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      sp_r       <= 14'd0;
      rm_r       <= 14'd0;
      presc_r    <= {PW{1'b0}};
      min_prev_r <= 1'b0;
      sec_prev_r <= 1'b0;
      m_tens     <= 3'd0;
      m_ones     <= 4'd0;
      s_tens     <= 3'd0;
      s_ones     <= 4'd0;
      state      <= 2'b00;
      alarm      <= 1'b0;
    end else if (enable) begin
      state_r    <= state_nxt_s;
      sp_r       <= sp_nxt_s;
      rm_r       <= rm_nxt_s;
      presc_r    <= presc_nxt_s;
      min_prev_r <= minutes;
      sec_prev_r <= seconds;
      m_tens     <= disp_nxt_s[13:11];
      m_ones     <= disp_nxt_s[10:7];
      s_tens     <= disp_nxt_s[6:4];
      s_ones     <= disp_nxt_s[3:0];
      state      <= state_nxt_s;
      alarm      <= (state_nxt_s == DONE);
    end
  end

`ifdef ALARM_TIMEOUT_EN
  // Alarm duration counter and restart interlock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acnt_r <= {CW{1'b0}};
      hold_r <= 1'b0;
    end else if (enable) begin
      acnt_r <= acnt_nxt_s;
      hold_r <= hold_nxt_s;
    end
  end
`endif

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// Scoreboard bench for egg_timer_ctrl: a seconds-based reference model predicts every cycle.
`timescale 1ns/1ps
module tb_egg_timer_ctrl;
  localparam int TICK_DIV   = 4;
  localparam int ALARM_SECS = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic cook_time = 1'b0;
  logic minutes = 1'b0;
  logic seconds = 1'b0;
  logic [2:0] m_tens, s_tens;
  logic [3:0] m_ones, s_ones;
  logic [1:0] state;
  logic       alarm;
  logic [16:0] dut_out;

  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q[$];

  int m_state, sp_m, sp_s, rem, presc, acnt;
  bit pm, ps, hold;

  egg_timer_ctrl #(.TICK_DIV(TICK_DIV), .ALARM_SECS(ALARM_SECS)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cook_time(cook_time),
    .minutes(minutes), .seconds(seconds),
    .m_tens(m_tens), .m_ones(m_ones), .s_tens(s_tens), .s_ones(s_ones),
    .state(state), .alarm(alarm)
  );

  assign dut_out = {state, alarm, m_tens, m_ones, s_tens, s_ones};

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [16:0] obs, input logic [16:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s observed %h expected %h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; sp_m = 0; sp_s = 0; rem = 0; presc = 0; acnt = 0;
    pm = 1'b0; ps = 1'b0; hold = 1'b0;
  endtask

  function automatic logic [16:0] model_out();
    int t;
    if (m_state == 0) t = sp_m * 60 + sp_s;
    else if (m_state == 3) t = 0;
    else t = rem;
    return {2'(m_state), (m_state == 3), 3'((t / 60) / 10), 4'((t / 60) % 10),
            3'((t % 60) / 10), 4'(t % 10)};
  endfunction

  task automatic model_step();
    bit me, se, tick, hold_old;
    int old_sp;
    if (!enable) return;
    me = minutes && !pm;
    se = seconds && !ps;
    tick = (presc == TICK_DIV - 1);
    old_sp = sp_m * 60 + sp_s;
    hold_old = hold;
    hold = hold && cook_time;
    case (m_state)
      0: begin
        if (se) sp_s = (sp_s + 1) % 60;
        if (me) sp_m = (sp_m + 1) % 60;
        if (cook_time && old_sp != 0 && !hold_old) begin
          m_state = 1; rem = old_sp; presc = 0;
        end
      end
      1: begin
        if (tick) begin rem--; presc = 0; end
        else presc++;
        if (rem == 0) m_state = 3;
        else if (!cook_time) m_state = 2;
      end
      2: begin
        if (minutes && seconds) m_state = 0;
        else if (cook_time) m_state = 1;
      end
      default: begin
`ifdef ALARM_TIMEOUT_EN
        if (tick) begin presc = 0; acnt++; end
        else presc++;
        if (!cook_time) m_state = 0;
        else if (acnt == ALARM_SECS) begin m_state = 0; hold = 1'b1; end
`else
        if (!cook_time) m_state = 0;
`endif
      end
    endcase
    if (m_state != 3) acnt = 0;
    pm = minutes;
    ps = seconds;
  endtask

  task automatic step(input string tag);
    model_step();
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) check_val("queue_empty", dut_out, 17'h1ffff);
    else check_val(tag, dut_out, exp_q.pop_front());
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    exp_q.delete();
    #1;
    check_val("reset_async", dut_out, 17'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    check_val("reset_release", dut_out, 17'd0);
  endtask

  task automatic press_sec(input int n);
    for (int i = 0; i < n; i++) begin
      seconds = 1'b1; step("sec_press");
      seconds = 1'b0; step("sec_release");
    end
  endtask

  task automatic press_min(input int n);
    for (int i = 0; i < n; i++) begin
      minutes = 1'b1; step("min_press");
      minutes = 1'b0; step("min_release");
    end
  endtask

  initial begin
    enable = 1'b1;
    #2;
    do_reset();

    // Setpoint entry with wrap and both fields.
    press_sec(59);
    press_sec(1);
    check_val("sec_wrap", dut_out, {2'b00, 1'b0, 3'd0, 4'd0, 3'd0, 4'd0});
    press_sec(1);
    press_min(2);
    check_val("set_0201", dut_out, {2'b00, 1'b0, 3'd0, 4'd2, 3'd0, 4'd1});

    // Button held across a disabled window is not a second edge.
    seconds = 1'b1; step("en_press");
    enable = 1'b0; repeat (5) step("en_frozen");
    enable = 1'b1; step("en_resume");
    seconds = 1'b0; step("en_release");
    check_val("en_no_edge", dut_out, {2'b00, 1'b0, 3'd0, 4'd2, 3'd0, 4'd2});

    // Zero setpoint never starts.
    do_reset();
    cook_time = 1'b1; repeat (5) step("zero_idle");
    cook_time = 1'b0; step("zero_idle_off");

    // Full countdown from 01:00.
    press_min(1);
    cook_time = 1'b1;
    repeat (241) step("run_0100");
    check_val("done_at_0000", dut_out, {2'b11, 1'b1, 14'd0});
    repeat (20) step("done_held");
    cook_time = 1'b0; repeat (2) step("done_exit");
    check_val("sp_retained", dut_out, {2'b00, 1'b0, 3'd0, 4'd1, 3'd0, 4'd0});

    // Pause keeps prescaler phase.
    do_reset();
    press_sec(30);
    cook_time = 1'b1; repeat (3) step("run_0030");
    cook_time = 1'b0; step("pause_enter");
    repeat (20) step("pause_hold");
    cook_time = 1'b1; repeat (3) step("resume");
    check_val("resume_0029", dut_out, {2'b01, 1'b0, 3'd0, 4'd0, 3'd2, 4'd9});

    // Cancel from PAUSE; buttons ignored while running.
    cook_time = 1'b0; step("pause2");
    minutes = 1'b1; seconds = 1'b1; step("cancel");
    minutes = 1'b0; seconds = 1'b0; step("cancel_rel");
    check_val("cancel_sp", dut_out, {2'b00, 1'b0, 3'd0, 4'd0, 3'd3, 4'd0});
    cook_time = 1'b1; step("run3");
    press_sec(3);
    press_min(2);
    cook_time = 1'b0; step("pause3");
    minutes = 1'b1; seconds = 1'b1; step("cancel3");
    minutes = 1'b0; seconds = 1'b0; step("cancel3_rel");
    check_val("run_btn_ignored", dut_out, {2'b00, 1'b0, 3'd0, 4'd0, 3'd3, 4'd0});

    // DONE with cook_time held high, then restart interlock.
    do_reset();
    press_sec(1);
    cook_time = 1'b1; repeat (6) step("short_run");
    repeat (20) step("done_cook_high");
    cook_time = 1'b0; step("cook_low");
    cook_time = 1'b1; repeat (6) step("restart");
    cook_time = 1'b0; repeat (2) step("restart_off");

    // Random traffic.
    repeat (400) begin
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) cook_time = ~cook_time;
      minutes = ($urandom_range(0, 3) == 0);
      seconds = ($urandom_range(0, 2) == 0);
      step("random");
    end
    enable = 1'b1; minutes = 1'b0; seconds = 1'b0; cook_time = 1'b0;
    step("random_end");

    // Asynchronous reset while running.
    do_reset();
    press_sec(5);
    cook_time = 1'b1; repeat (7) step("pre_reset_run");
    do_reset();
    cook_time = 1'b0; step("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
